mul_issue_wb_unit: RTL
======================

# mul_issue_wb_unit

Issue/writeback wrapper for the RV32M multiply path. It feeds operands to the 9-cycle fully pipelined signed 32x32 Booth–Wallace multiplier and consumes its 64-bit product. It tracks each in-flight op's type and destination register in a delay line aligned to the multiplier pipeline. It applies the unsigned-operand corrections for MULHSU/MULHU and drives a registered writeback port to the register-file stage.

## Interface
- `MUL_LATENCY`, default 9: edges from operands presented on `mul_a`/`mul_b` until the product is stable on `mul_p`. The block is correct only when this matches the multiplier instance.
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `issue_valid`  in  1: op offered this cycle.
- `issue_ready`  out  1: equals `~flush`. An op is accepted on a rising edge where `issue_valid & issue_ready`.
- `issue_op`  in  2: funct3[1:0] encoding: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `issue_rs1`, `issue_rs2`  in  32 each: operands.
- `issue_rd`  in  5: destination tag.
- `flush`  in  1: kills all in-flight ops.
- `mul_a`, `mul_b`  out  32 each: combinational pass-through of `issue_rs1`/`issue_rs2` (the multiplier registers them).
- `mul_p`  in  64: signed product from the multiplier. Its `valid` output is ignored.
- `wb_valid`  out  1: one-cycle pulse per completed op.
- `wb_rd`  out  5: destination tag of the completed op.
- `wb_data`  out  32: result.
- `busy`  out  1: OR of all delay-line valid bits and `wb_valid`.

## Operation
- **Accept.** On acceptance, compute a 32-bit correction term `corr`, mod 2^32:
  - MULHU: `(rs1[31] ? rs2 : 0) + (rs2[31] ? rs1 : 0)`
  - MULHSU: `rs2[31] ? rs1 : 0`
  - MUL, MULH: 0
- **Delay line.** `MUL_LATENCY` entries of {valid, op, rd, corr}. Entry 0 loads on the accept edge (valid=0 if no accept). Every entry shifts each edge with no stall; the multiplier has no enable.
- **Alignment.** The last entry's contents correspond to the current `mul_p`.
- **Result select** (registered into `wb_*`):
  - MUL → `mul_p[31:0]`
  - MULH → `mul_p[63:32]`
  - MULHSU, MULHU → `mul_p[63:32] + corr` (mod 2^32)
- **wb_valid.** Equals the last entry's valid bit, registered.
- **Ordering.** Results retire in issue order. Back-to-back issue every cycle is supported (throughput 1 op/cycle).
- **Flush.**
  - At the edge where `flush`=1, all delay-line valid bits and `wb_valid` clear. rd/corr/data may retain stale values.
  - Because `issue_ready`=0, an op offered in the flush cycle is not accepted.
  - Products still draining through the multiplier are discarded, since their valid bits are gone.
- **Reset** (async, any time): all valid bits 0; `wb_valid`=0, `wb_rd`=0, `wb_data`=0; `busy`=0. In-flight ops are lost. `issue_ready` follows `flush` combinationally during reset.

## Timing
- Accept at edge E:
  - multiplier input register loads at E;
  - `mul_p` holds the product after edge E+8;
  - `wb_*` loads at edge E+9.
- `wb_valid` is high for exactly the cycle after E+9: 10 cycles issue-to-writeback.
- Flush asserted in the cycle before edge F: any op whose writeback edge is F or later never produces `wb_valid`. The `wb_valid` pulse from the edge before F is dropped at F.
- A new op accepted at F+1 writes back at F+10 normally.
- `busy` is combinational from registered state.

## Structure
- A shared package holds:
  - the op encoding constants `MUL_OP_MUL`/`MULH`/`MULHSU`/`MULHU`;
  - the default `MUL_LATENCY`=9;
  - the delay-line entry field widths (rd 5, corr 32).
- One sub-module, `mul_tag_pipe`: a parameterised shift register of {valid, op, rd, corr} with async reset and a synchronous valid-clear on flush.
- The correction adder and result mux stay in the top.
- The multiplier is instantiated alongside this block at the next level, not inside it.

## Test plan
- MUL, rs1=7, rs2=0xFFFFFFFD (−3), rd=5 → `wb_valid` 10 cycles later, `wb_rd`=5, `wb_data`=0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → `wb_data`=0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Four consecutive-cycle ops (MUL, MULH, MULHSU, MULHU; rd 1–4; random operands) → four consecutive `wb_valid` cycles, rd 1,2,3,4 in order, each data matching a 64-bit golden model.
- Issue 3 ops, assert `flush` 4 cycles after the first, and offer an op in the flush cycle → `issue_ready`=0 that cycle, no `wb_valid` ever, `busy`=0 after the flush edge. An op issued the next cycle writes back correctly 10 cycles later.
- Assert `rst` mid-flight for 1 cycle → `wb_*`=0 immediately, no stale writeback afterward. An op issued after release completes with latency 10.
- Idle with random `mul_p` noise → `wb_valid` stays 0.

Source files
------------

// File: rtl/mul_issue_wb_unit_pkg.sv
// Shared definitions for the RV32M multiply issue/writeback wrapper.
//   - op encoding (funct3[1:0])
//   - default multiplier latency
//   - tag delay-line entry layout and field widths
//   - correction-term helper for the unsigned-operand high-half ops
package mul_issue_wb_unit_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    localparam int MUL_LATENCY_DEFAULT = 9;
    localparam int TAG_RD_W            = 5;
    localparam int TAG_CORR_W          = 32;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            op;
        logic [TAG_RD_W-1:0]   rd;
        logic [TAG_CORR_W-1:0] corr;
    } tag_t;

    // The multiplier always treats both operands as signed. An operand with
    // bit 31 set that should have been unsigned is short by 2^32 * other,
    // which lands entirely in the high word; adding the other operand back
    // into the high word fixes it.
    function automatic logic [TAG_CORR_W-1:0] calc_corr(
        input logic [1:0]  op,
        input logic [31:0] rs1,
        input logic [31:0] rs2
    );
        logic [TAG_CORR_W-1:0] corr;
        corr = '0;
        case (op)
            MUL_OP_MULHU:  corr = (rs1[31] ? rs2 : 32'd0) + (rs2[31] ? rs1 : 32'd0);
            MUL_OP_MULHSU: corr = rs2[31] ? rs1 : 32'd0;
            default:       corr = '0;
        endcase
        return corr;
    endfunction

endpackage

// File: rtl/mul_issue_wb_unit_tag_pipe.sv
// mul_tag_pipe: fixed-depth shift register of {valid, op, rd, corr} tags that
// travels alongside the multiplier pipeline. Shifts every clock (no stall).
// Ports:
//   clk, rst            clock, async active-high reset
//   flush               synchronous clear of every valid bit
//   in_valid/op/rd/corr entry 0 load values
//   out_valid/op/rd/corr last entry (aligned with the multiplier output)
//   any_valid           OR of all valid bits
module mul_tag_pipe
    import mul_issue_wb_unit_pkg::*;
#(
    parameter int DEPTH = MUL_LATENCY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [1:0]            in_op,
    input  logic [TAG_RD_W-1:0]   in_rd,
    input  logic [TAG_CORR_W-1:0] in_corr,
    output logic                  out_valid,
    output logic [1:0]            out_op,
    output logic [TAG_RD_W-1:0]   out_rd,
    output logic [TAG_CORR_W-1:0] out_corr,
    output logic                  any_valid
);

    tag_t pipe [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= in_valid & ~flush;
            pipe[0].op    <= in_op;
            pipe[0].rd    <= in_rd;
            pipe[0].corr  <= in_corr;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i].valid <= pipe[i-1].valid & ~flush;
                pipe[i].op    <= pipe[i-1].op;
                pipe[i].rd    <= pipe[i-1].rd;
                pipe[i].corr  <= pipe[i-1].corr;
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | pipe[i].valid;
        end
    end

    assign out_valid = pipe[DEPTH-1].valid;
    assign out_op    = pipe[DEPTH-1].op;
    assign out_rd    = pipe[DEPTH-1].rd;
    assign out_corr  = pipe[DEPTH-1].corr;

endmodule

// File: rtl/mul_issue_wb_unit.sv
// mul_issue_wb_unit: issue/writeback wrapper around an external fully
// pipelined signed 32x32 multiplier. Tracks in-flight ops in a tag pipe of
// MUL_LATENCY entries, applies the MULHSU/MULHU high-word correction and
// registers the result onto the writeback port.
// Ports:
//   clk, rst                          clock, async active-high reset
//   issue_valid/ready/op/rs1/rs2/rd   issue handshake (ready = ~flush)
//   flush                             kill all in-flight ops
//   mul_a, mul_b                      operands to the multiplier (pass-through)
//   mul_p                             signed 64-bit product from the multiplier
//   wb_valid, wb_rd, wb_data          registered writeback
//   busy                              any op in flight or writing back
module mul_issue_wb_unit
    import mul_issue_wb_unit_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [1:0]  issue_op,
    input  logic [31:0] issue_rs1,
    input  logic [31:0] issue_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
);

    logic                  accept;
    logic [TAG_CORR_W-1:0] issue_corr;
    logic                  tail_valid;
    logic [1:0]            tail_op;
    logic [TAG_RD_W-1:0]   tail_rd;
    logic [TAG_CORR_W-1:0] tail_corr;
    logic                  pipe_busy;
    logic [31:0]           result;

    assign issue_ready = ~flush;
    assign accept      = issue_valid & issue_ready;
    assign mul_a       = issue_rs1;
    assign mul_b       = issue_rs2;
    assign issue_corr  = calc_corr(issue_op, issue_rs1, issue_rs2);

    mul_tag_pipe #(
        .DEPTH (MUL_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (accept),
        .in_op     (issue_op),
        .in_rd     (issue_rd),
        .in_corr   (issue_corr),
        .out_valid (tail_valid),
        .out_op    (tail_op),
        .out_rd    (tail_rd),
        .out_corr  (tail_corr),
        .any_valid (pipe_busy)
    );

    always_comb begin
        result = mul_p[63:32];
        case (tail_op)
            MUL_OP_MUL:    result = mul_p[31:0];
            MUL_OP_MULH:   result = mul_p[63:32];
            MUL_OP_MULHSU,
            MUL_OP_MULHU:  result = mul_p[63:32] + tail_corr;
            default:       result = mul_p[63:32];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= tail_valid & ~flush;
            // Data only moves on a real completion so idle noise on mul_p
            // never shows up on the writeback bus.
            if (tail_valid & ~flush) begin
                wb_rd   <= tail_rd;
                wb_data <= result;
            end
        end
    end

    assign busy = pipe_busy | wb_valid;

endmodule
